hier_fanout_node: RTL and testbench

//  Parametrised successor to the fixed five-child structural hierarchy node. It routes one

---
 rtl/hier_node_pkg.sv | 23 ++
 rtl/hier_fanout_node_if.sv | 37 +++
 rtl/hier_rr_arbiter.sv | 45 ++++
 rtl/hier_fanout_node.sv | 148 ++++++++++++++
 tb/tb_hier_fanout_node.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared widths, types and helpers for the hierarchy fan-out node
package hier_node_pkg;

  localparam int MAX_CHILD   = 16;
  localparam int MAX_CHILD_W = $clog2(MAX_CHILD);
  localparam int NODE_DATA_W = 32;
  localparam int CNT_W       = 4;

  function automatic int child_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_CHILD_W-1:0] dest;
    logic [NODE_DATA_W-1:0] data;
  } node_req_t;

  typedef struct packed {
    logic [MAX_CHILD_W-1:0] src;
    logic [NODE_DATA_W-1:0] data;
  } node_rsp_t;

endpackage

// File: rtl/hier_fanout_node_if.sv
// rtl/hier_fanout_node_if.sv - upstream and per-child request/response bundle of one tree node
interface hier_fanout_node_if #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32
);
  import hier_node_pkg::*;
  localparam int CHILD_W = child_w(NUM_CHILD);

  logic                        req_valid;
  logic                        req_ready;
  logic [CHILD_W-1:0]          req_dest;
  logic [DATA_W-1:0]           req_data;
  logic                        req_err;
  logic [NUM_CHILD-1:0]        ch_req_valid;
  logic [NUM_CHILD-1:0]        ch_req_ready;
  logic [DATA_W-1:0]           ch_req_data;
  logic [NUM_CHILD-1:0]        ch_rsp_valid;
  logic [NUM_CHILD-1:0]        ch_rsp_ready;
  logic [NUM_CHILD*DATA_W-1:0] ch_rsp_data;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [CHILD_W-1:0]          rsp_src;
  logic [DATA_W-1:0]           rsp_data;

  modport master (
    output req_valid, req_dest, req_data, ch_req_ready, ch_rsp_valid, ch_rsp_data, rsp_ready,
    input  req_ready, req_err, ch_req_valid, ch_req_data, ch_rsp_ready, rsp_valid, rsp_src,
           rsp_data
  );

  modport slave (
    input  req_valid, req_dest, req_data, ch_req_ready, ch_rsp_valid, ch_rsp_data, rsp_ready,
    output req_ready, req_err, ch_req_valid, ch_req_data, ch_rsp_ready, rsp_valid, rsp_src,
           rsp_data
  );

endinterface

// File: rtl/hier_rr_arbiter.sv
// rtl/hier_rr_arbiter.sv - round-robin arbiter; pointer moves past the winner on advance
module hier_rr_arbiter
  import hier_node_pkg::*;
#(
  parameter int N = 5,
  localparam int IDX_W = child_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] r_ptr;
  int               w_scan;

  // Scan from the pointer, wrapping once; first requester wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_scan      = 0;
    for (int k = 0; k < N; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= N) w_scan = w_scan - N;
      if (!o_any && i_req[IDX_W'(w_scan)]) begin
        o_grant[IDX_W'(w_scan)] = 1'b1;
        o_grant_idx             = IDX_W'(w_scan);
        o_any                   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hier_fanout_node.sv
// rtl/hier_fanout_node.sv - routes requests to NUM_CHILD children, merges responses round-robin
// Optional HIER_NODE_PERF_EN adds request/response/stall counters.
module hier_fanout_node
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input logic                clk,
  input logic                rst,
  hier_fanout_node_if.slave  bus
`ifdef HIER_NODE_PERF_EN
  ,
  output logic [31:0]        perf_req_cnt,
  output logic [31:0]        perf_rsp_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int               CHILD_W = child_w(NUM_CHILD);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic                 r_held;
  logic [CHILD_W-1:0]   r_dest;
  logic [DATA_W-1:0]    r_data;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt [NUM_CHILD];
  logic                 r_rsp_valid;
  logic [CHILD_W-1:0]   r_rsp_src;
  logic [DATA_W-1:0]    r_rsp_data;

  logic                 w_blocked;
  logic                 w_dest_ok;
  logic                 w_fwd;
  logic                 w_accept;
  logic                 w_load_en;
  logic                 w_any;
  logic [CHILD_W-1:0]   w_grant_idx;
  logic [NUM_CHILD-1:0] w_grant;
  logic [NUM_CHILD-1:0] w_ch_req_valid;
  logic [NUM_CHILD-1:0] w_up;
  logic [NUM_CHILD-1:0] w_dn;

  // Only in-range destinations are ever held, so r_dest always indexes a real child.
  assign w_blocked = (r_cnt[r_dest] == MAX_CNT);
  assign w_dest_ok = (int'(bus.req_dest) < NUM_CHILD);

  always_comb begin
    w_ch_req_valid = '0;
    if (r_held && !w_blocked) w_ch_req_valid[r_dest] = 1'b1;
  end

  assign w_fwd    = |(w_ch_req_valid & bus.ch_req_ready);
  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_up     = w_ch_req_valid & bus.ch_req_ready;
  assign w_dn     = bus.ch_rsp_ready & bus.ch_rsp_valid;

  assign bus.req_ready    = ~rst & (~r_held | w_fwd);
  assign bus.req_err      = r_err;
  assign bus.ch_req_valid = w_ch_req_valid;
  assign bus.ch_req_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_dest_ok;
      if (w_accept && w_dest_ok) begin
        r_held <= 1'b1;
        r_dest <= bus.req_dest;
        r_data <= bus.req_data;
      end else if (w_fwd) begin
        r_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
      end else if (w_up[i] && !w_dn[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (!w_up[i] && w_dn[i] && r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // The output register refills in the same cycle it drains.
  assign w_load_en = ~rst & (~r_rsp_valid | bus.rsp_ready);

  hier_rr_arbiter #(.N(NUM_CHILD)) u_rsp_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.ch_rsp_valid),
    .i_advance   (w_load_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign bus.ch_rsp_ready = w_load_en ? w_grant : '0;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_src      = r_rsp_src;
  assign bus.rsp_data     = r_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= '0;
      r_rsp_data  <= '0;
    end else if (w_load_en) begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_rsp_src  <= w_grant_idx;
        r_rsp_data <= bus.ch_rsp_data[int'(w_grant_idx)*DATA_W +: DATA_W];
      end
    end
  end

`ifdef HIER_NODE_PERF_EN
  logic [31:0] r_perf_req;
  logic [31:0] r_perf_rsp;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_req   <= '0;
      r_perf_rsp   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept) r_perf_req <= r_perf_req + 32'd1;
      if (r_rsp_valid && bus.rsp_ready) r_perf_rsp <= r_perf_rsp + 32'd1;
      if (r_held && w_blocked) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_req_cnt   = r_perf_req;
  assign perf_rsp_cnt   = r_perf_rsp;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_hier_fanout_node.sv
// tb/tb_hier_fanout_node.sv - directed vectors and randomized scoreboard for hier_fanout_node
module tb_hier_fanout_node;
  import hier_node_pkg::*;

  localparam int NC = 5;
  localparam int DW = 32;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hier_fanout_node_if #(.NUM_CHILD(NC), .DATA_W(DW)) ifc ();

  hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] data;
    logic [4:0]  exp_v;
    logic        exp_err;
  } vec_t;
  vec_t vt [7];

  typedef logic [31:0] dq_t[$];
  node_req_t fq[$];
  node_rsp_t rq[$];
  dq_t       cq [NC];
  int        cnt [NC];
  int        rr;
  logic      exp_err;
  int        fair_exp [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ifc.req_valid    = 1'b0;
    ifc.req_dest     = '0;
    ifc.req_data     = '0;
    ifc.ch_req_ready = '0;
    ifc.ch_rsp_valid = '0;
    ifc.ch_rsp_data  = '0;
    ifc.rsp_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_rsp(input int i, input logic [31:0] d);
    ifc.ch_rsp_data[i*DW +: DW] = d;
  endtask

  // Transaction-level model: observe the cycle's inputs, predict outputs, then commit handshakes.
  task automatic model_step();
    logic [NC-1:0] ev;
    logic [NC-1:0] eg;
    logic          er;
    logic          ld;
    int            gi;
    node_req_t     h;
    check("req_err", ifc.req_err, exp_err);
    ev = '0;
    if (fq.size() != 0 && cnt[fq[0].dest] < MO) ev[fq[0].dest] = 1'b1;
    check("ch_req_valid", ifc.ch_req_valid, ev);
    er = (fq.size() == 0) || ((ev & ifc.ch_req_ready) != '0);
    check("req_ready", ifc.req_ready, er);
    if (ev != '0) check("ch_req_data", ifc.ch_req_data, fq[0].data);
    check("rsp_valid", ifc.rsp_valid, rq.size() != 0);
    if (rq.size() != 0) begin
      check("rsp_src", ifc.rsp_src, rq[0].src);
      check("rsp_data", ifc.rsp_data, rq[0].data);
    end
    ld = (rq.size() == 0) || ifc.rsp_ready;
    eg = '0;
    gi = -1;
    if (ld) begin
      for (int k = 0; k < NC; k++) begin
        int j;
        j = (rr + k) % NC;
        if (gi < 0 && ifc.ch_rsp_valid[j]) gi = j;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    check("ch_rsp_ready", ifc.ch_rsp_ready, eg);

    if ((ev & ifc.ch_req_ready) != '0) begin
      h = fq.pop_front();
      cnt[h.dest]++;
      cq[h.dest].push_back(h.data);
    end
    if (rq.size() != 0 && ifc.rsp_ready) void'(rq.pop_front());
    if (gi >= 0) begin
      rq.push_back(node_rsp_t'{src: 4'(gi), data: ifc.ch_rsp_data[gi*DW +: DW]});
      if (cq[gi].size() != 0) void'(cq[gi].pop_front());
      if (cnt[gi] > 0) cnt[gi]--;
      rr = (gi + 1) % NC;
    end
    exp_err = 1'b0;
    if (ifc.req_valid && er) begin
      if (int'(ifc.req_dest) < NC)
        fq.push_back(node_req_t'{dest: 4'(ifc.req_dest), data: ifc.req_data});
      else
        exp_err = 1'b1;
    end
  endtask

  initial begin
    vt[0] = '{3'd3, 32'hA5A5_0003, 5'b01000, 1'b0};
    vt[1] = '{3'd0, 32'h1111_0000, 5'b00001, 1'b0};
    vt[2] = '{3'd4, 32'h4444_0004, 5'b10000, 1'b0};
    vt[3] = '{3'd6, 32'hDEAD_0006, 5'b00000, 1'b1};
    vt[4] = '{3'd5, 32'hDEAD_0005, 5'b00000, 1'b1};
    vt[5] = '{3'd7, 32'hDEAD_0007, 5'b00000, 1'b1};
    vt[6] = '{3'd1, 32'h0BAD_F00D, 5'b00010, 1'b0};
    fair_exp = '{0, 2, 4, 0, 2, 4};

    // Reset held with every input active.
    rst              = 1'b1;
    ifc.req_valid    = 1'b1;
    ifc.req_dest     = 3'd2;
    ifc.req_data     = 32'hFFFF_FFFF;
    ifc.ch_req_ready = '1;
    ifc.ch_rsp_valid = '1;
    ifc.ch_rsp_data  = '1;
    ifc.rsp_ready    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst ch_req_valid", ifc.ch_req_valid, 0);
      check("rst rsp_valid", ifc.rsp_valid, 0);
      check("rst req_err", ifc.req_err, 0);
      check("rst req_ready", ifc.req_ready, 0);
      check("rst ch_rsp_ready", ifc.ch_rsp_ready, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post-rst req_ready", ifc.req_ready, 1);
    check("post-rst rsp_src", ifc.rsp_src, 0);
    check("post-rst rsp_data", ifc.rsp_data, 0);
    check("post-rst ch_req_data", ifc.ch_req_data, 0);

    // Routing and out-of-range table.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      ifc.ch_req_ready = '1;
      ifc.req_valid    = 1'b1;
      ifc.req_dest     = vt[v].dest;
      ifc.req_data     = vt[v].data;
      @(negedge clk);
      check("vec req_ready", ifc.req_ready, 1);
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      check("vec ch_req_valid", ifc.ch_req_valid, vt[v].exp_v);
      check("vec req_err", ifc.req_err, vt[v].exp_err);
      if (vt[v].exp_v != '0) check("vec ch_req_data", ifc.ch_req_data, vt[v].data);
      @(negedge clk);
      check("vec req_err gone", ifc.req_err, 0);
      check("vec ch_req_valid gone", ifc.ch_req_valid, 0);
    end

    // Outstanding limit on child 1.
    do_reset();
    ifc.ch_req_ready = '1;
    ifc.rsp_ready    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifc.req_valid = 1'b1;
      ifc.req_dest  = 3'd1;
      ifc.req_data  = 32'h100 + k;
      @(posedge clk);
      #1;
    end
    ifc.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("outst held valid", ifc.ch_req_valid, 0);
      check("outst held ready", ifc.req_ready, 0);
    end
    @(posedge clk);
    #1;
    ifc.ch_rsp_valid = 5'b00010;
    set_rsp(1, 32'hBEEF);
    @(negedge clk);
    check("outst rsp grant", ifc.ch_rsp_ready, 5'b00010);
    @(posedge clk);
    #1;
    ifc.ch_rsp_valid = '0;
    @(negedge clk);
    check("outst third issues", ifc.ch_req_valid, 5'b00010);
    check("outst third data", ifc.ch_req_data, 32'h102);
    check("outst rsp_src", ifc.rsp_src, 1);
    check("outst rsp_data", ifc.rsp_data, 32'hBEEF);

    // Fairness among children 0, 2, 4.
    do_reset();
    ifc.rsp_ready    = 1'b1;
    ifc.ch_rsp_valid = 5'b10101;
    for (int i = 0; i < NC; i++) set_rsp(i, 32'hC0 + i);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("fair rsp_valid", ifc.rsp_valid, 1);
      check("fair rsp_src", ifc.rsp_src, fair_exp[k]);
      check("fair rsp_data", ifc.rsp_data, 32'hC0 + fair_exp[k]);
    end

    // Upstream backpressure with children 1 and 3 pending.
    do_reset();
    ifc.ch_rsp_valid = 5'b01010;
    set_rsp(1, 32'h11);
    set_rsp(3, 32'h33);
    @(negedge clk);
    check("bp first grant", ifc.ch_rsp_ready, 5'b00010);
    @(posedge clk);
    #1;
    ifc.ch_rsp_valid[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp rsp_valid", ifc.rsp_valid, 1);
      check("bp rsp_src", ifc.rsp_src, 1);
      check("bp rsp_data", ifc.rsp_data, 32'h11);
      check("bp no grant", ifc.ch_rsp_ready, 0);
    end
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp drain src", ifc.rsp_src, 1);
    check("bp second grant", ifc.ch_rsp_ready, 5'b01000);
    @(posedge clk);
    #1;
    ifc.ch_rsp_valid = '0;
    @(negedge clk);
    check("bp second valid", ifc.rsp_valid, 1);
    check("bp second src", ifc.rsp_src, 3);
    check("bp second data", ifc.rsp_data, 32'h33);
    @(negedge clk);
    check("bp empty", ifc.rsp_valid, 0);

    // Randomized traffic against the scoreboard.
    do_reset();
    fq.delete();
    rq.delete();
    for (int i = 0; i < NC; i++) begin
      cq[i].delete();
      cnt[i] = 0;
    end
    rr      = 0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        #1;
      end
      ifc.req_valid = ($urandom_range(0, 2) != 0);
      ifc.req_dest  = 3'($urandom_range(0, 7));
      ifc.req_data  = $urandom;
      ifc.rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NC; i++) begin
        ifc.ch_req_ready[i] = ($urandom_range(0, 3) != 0);
        if (cq[i].size() != 0 && $urandom_range(0, 9) < 6) begin
          ifc.ch_rsp_valid[i] = 1'b1;
          set_rsp(i, cq[i][0] ^ 32'hFFFF_0000);
        end else if (cq[i].size() == 0 && $urandom_range(0, 49) == 0) begin
          ifc.ch_rsp_valid[i] = 1'b1;
          set_rsp(i, $urandom);
        end else begin
          ifc.ch_rsp_valid[i] = 1'b0;
          set_rsp(i, $urandom);
        end
      end
      @(negedge clk);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
